snake_board_buffer: RTL and testbench

Double-buffered board memory between the snake game logic and the VGA display path. Game logic writes a complete board (one 16-bit tile word per address) plus a score into the back bank, then requests a commit. The buffer swaps banks only on the frame boundary pulse, so the display never shows a half-written board. The VGA side reads the front bank through its `re`/`raddr` port and receives `state` and `score` directly.

---
 rtl/snake_board_buffer.sv | 112 +++++++++++
 tb/tb_snake_board_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/snake_board_buffer.sv
// Double-buffered board RAM: game logic fills the back bank, display reads the front bank, banks swap at frame start.
// Latency: display read 1 cycle; commit to busy 1 cycle; swap on the first frame_start while pending.
// Backpressure: writes while pending or out of range are dropped and flagged by wr_dropped one cycle later.
module snake_board_buffer #(
    parameter int DEPTH = 768,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [9:0]    score_in,
    input  logic          commit,
    input  logic          frame_start,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   state,
    output logic [9:0]    score,
    output logic          busy,
    output logic          wr_dropped,
    output logic          front_bank
);
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, PENDING} fsm_t;

    fsm_t        fsm_q;
    logic        front_q;
    logic        busy_q;
    logic        drop_q;
    logic [9:0]  score_q;
    logic [9:0]  shadow_q;

    logic [15:0] bank0 [DEPTH];
    logic [15:0] bank1 [DEPTH];
    logic [15:0] rd0_q;
    logic [15:0] rd1_q;
    logic        rsel_q;
    logic        rzero_q;

    logic        w_in_range;
    logic        r_in_range;
    logic        wr_ok;

    assign w_in_range = {1'b0, waddr} < LIMIT;
    assign r_in_range = {1'b0, raddr} < LIMIT;
    assign wr_ok      = we && (fsm_q == IDLE) && w_in_range;

    // Plain block-RAM style ports: no reset on the arrays or their read registers.
    always_ff @(posedge clk) begin
        if (wr_ok && front_q) begin
            bank0[waddr] <= wdata;
        end
        if (wr_ok && !front_q) begin
            bank1[waddr] <= wdata;
        end
        if (re && r_in_range) begin
            rd0_q <= bank0[raddr];
            rd1_q <= bank1[raddr];
        end
    end

    // Bank select and out-of-range mask are captured with the read, so a read in
    // the swap cycle still returns the pre-swap bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsel_q  <= 1'b0;
            rzero_q <= 1'b1;
        end else if (re) begin
            rsel_q  <= front_q;
            rzero_q <= !r_in_range;
        end
    end

    assign state = rzero_q ? 16'h0000 : (rsel_q ? rd1_q : rd0_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q    <= IDLE;
            front_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            score_q  <= 10'd0;
            shadow_q <= 10'd0;
        end else begin
            drop_q <= we && ((fsm_q == PENDING) || !w_in_range);
            case (fsm_q)
                IDLE: begin
                    if (commit) begin
                        fsm_q    <= PENDING;
                        busy_q   <= 1'b1;
                        shadow_q <= score_in;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        fsm_q   <= IDLE;
                        busy_q  <= 1'b0;
                        front_q <= ~front_q;
                        score_q <= shadow_q;
                    end
                end
            endcase
        end
    end

    assign score      = score_q;
    assign busy       = busy_q;
    assign wr_dropped = drop_q;
    assign front_bank = front_q;
endmodule

// File: tb/tb_snake_board_buffer.sv
// Bench for snake_board_buffer: behavioural model plus read scoreboard.
module tb_snake_board_buffer;
    localparam int DEPTH = 768;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic [9:0]    score_in;
    logic          commit;
    logic          frame_start;
    logic          re;
    logic [AW-1:0] raddr;
    logic [15:0]   state;
    logic [9:0]    score;
    logic          busy;
    logic          wr_dropped;
    logic          front_bank;

    snake_board_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .score_in(score_in), .commit(commit), .frame_start(frame_start),
        .re(re), .raddr(raddr), .state(state), .score(score), .busy(busy),
        .wr_dropped(wr_dropped), .front_bank(front_bank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mem [2][DEPTH];
    logic        m_front, m_busy, m_drop;
    logic [9:0]  m_score, m_shadow;
    logic [15:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we = 0; waddr = '0; wdata = '0; commit = 0; frame_start = 0; re = 0; raddr = '0;
    endtask

    task automatic model_reset();
        m_front = 0; m_busy = 0; m_drop = 0; m_score = 0; m_shadow = 0;
        exp_q.delete();
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic tick();
        logic rd;
        logic [15:0] e;
        rd = re;
        if (re) begin
            e = (int'(raddr) < DEPTH) ? m_mem[m_front][raddr] : 16'h0000;
            exp_q.push_back(e);
        end
        m_drop = we && (m_busy || int'(waddr) >= DEPTH);
        if (we && !m_busy && int'(waddr) < DEPTH) m_mem[!m_front][waddr] = wdata;
        if (!m_busy && commit) begin
            m_busy = 1; m_shadow = score_in;
        end else if (m_busy && frame_start) begin
            m_busy = 0; m_front = !m_front; m_score = m_shadow;
        end
        @(posedge clk);
        #1;
        if (rd) begin
            if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
            else check("rd_state", 32'(state), 32'(exp_q.pop_front()));
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("front", 32'(front_bank), 32'(m_front));
        check("score", 32'(score), 32'(m_score));
        check("wr_dropped", 32'(wr_dropped), 32'(m_drop));
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        idle_inputs(); we = 1; waddr = AW'(a); wdata = d; tick();
    endtask

    task automatic rd(input int a);
        idle_inputs(); re = 1; raddr = AW'(a); tick();
    endtask

    task automatic pulse_frame();
        idle_inputs(); frame_start = 1; tick();
    endtask

    initial begin
        idle_inputs();
        score_in = '0;
        model_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        re = 1; raddr = AW'(5);
        check("rst_state", 32'(state), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_front", 32'(front_bank), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(wr_dropped), 32'h0);
        reset = 0;
        idle_inputs();
        tick();

        // First board into bank 1; last write shares the commit cycle.
        score_in = 10'd42;
        wr(5, 16'hA5A5);
        idle_inputs(); we = 1; waddr = AW'(767); wdata = 16'h1234; commit = 1; tick();
        check("commit_busy", 32'(busy), 32'h1);
        tick();
        pulse_frame();
        check("swap_front", 32'(front_bank), 32'h1);
        check("swap_score", 32'(score), 32'd42);
        rd(5);
        rd(767);
        rd(768);
        check("oor_read_zero", 32'(state), 32'h0);

        // Second board into bank 0; commit together with frame_start must not swap.
        score_in = 10'd7;
        wr(5, 16'h0555);
        idle_inputs(); commit = 1; frame_start = 1; tick();
        check("no_swap_same_cycle", 32'(front_bank), 32'h1);
        wr(5, 16'hFFFF);
        check("drop_pending", 32'(wr_dropped), 32'h1);
        idle_inputs(); tick();
        check("drop_one_cycle", 32'(wr_dropped), 32'h0);
        wr(768, 16'hDEAD);
        score_in = 10'd99;
        idle_inputs(); commit = 1; tick();
        pulse_frame();
        check("second_score", 32'(score), 32'd7);
        rd(5);
        check("dropped_write_absent", 32'(state), 32'h0555);
        wr(768, 16'hBAD0);
        check("drop_oor_idle", 32'(wr_dropped), 32'h1);

        // Continuous reads across a swap edge.
        score_in = 10'd3;
        wr(5, 16'hBEEF);
        idle_inputs(); commit = 1; tick();
        idle_inputs(); re = 1; raddr = AW'(5); tick();
        frame_start = 1; tick();
        check("read_at_swap_old", 32'(state), 32'h0555);
        frame_start = 0; tick();
        check("read_after_swap_new", 32'(state), 32'hBEEF);
        rd(5);

        // Reset while pending: clears immediately, pending commit lost.
        score_in = 10'd11;
        wr(5, 16'h1111);
        idle_inputs(); commit = 1; tick();
        check("pending_before_reset", 32'(busy), 32'h1);
        reset = 1;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_front", 32'(front_bank), 32'h0);
        check("async_rst_score", 32'(score), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
        pulse_frame();
        check("no_swap_after_reset", 32'(front_bank), 32'h0);
        rd(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
